// File: rtl/piano_pkg.sv
// Shared definitions for the PS/2 piano voice path.
// Contents:
//   - arb_state_e     : voice arbiter FSM states
//   - SC_*            : PS/2 set-2 make codes of the note keys
//   - CLK_HZ          : system clock rate the half-period table is built for
//   - HP_*            : half-period counts for the tone divider
//   - halfPeriodFor() : scan code -> half-period count, 0 when the key has no note
package piano_pkg;

    localparam int unsigned CLK_HZ = 50_000_000;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOOKUP  = 2'd1,
        ST_EDIT    = 2'd2,
        ST_PUBLISH = 2'd3
    } arb_state_e;

    localparam logic [7:0] SC_A = 8'h1C;
    localparam logic [7:0] SC_S = 8'h1B;
    localparam logic [7:0] SC_D = 8'h23;
    localparam logic [7:0] SC_F = 8'h2B;
    localparam logic [7:0] SC_G = 8'h34;

    // CLK_HZ / (2 * f_note), rounded to the nearest count
    localparam int unsigned HP_C4 = 95556;
    localparam int unsigned HP_D4 = 85131;
    localparam int unsigned HP_E4 = 75843;
    localparam int unsigned HP_F4 = 71586;
    localparam int unsigned HP_G4 = 63776;

    function automatic int unsigned halfPeriodFor(input logic [7:0] code);
        int unsigned hp;
        case (code)
            SC_A:    hp = HP_C4;
            SC_S:    hp = HP_D4;
            SC_D:    hp = HP_E4;
            SC_F:    hp = HP_F4;
            SC_G:    hp = HP_G4;
            default: hp = 0;
        endcase
        return hp;
    endfunction

endpackage

// File: rtl/note_period_rom.sv
// Scan code to half-period lookup with a registered output.
// Ports:
//   clk      in   1   system clock
//   rst_n    in   1   asynchronous active-low reset
//   code_i   in   8   PS/2 make code
//   period_o out  PW  half-period count one cycle after code_i, 0 = unmapped key
module note_period_rom
    import piano_pkg::*;
#(
    parameter int PW = 26
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [7:0]    code_i,
    output logic [PW-1:0] period_o
);

    logic [PW-1:0] period_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_q <= '0;
        end else begin
            period_q <= PW'(halfPeriodFor(code_i));
        end
    end

    assign period_o = period_q;

endmodule

// File: rtl/note_voice_arbiter.sv
// Last-note-priority voice arbiter between the PS/2 receiver and the tone divider.
// Held keys live in a small stack (slot 0 = newest); the top slot drives the tone.
// Ports:
//   clkB        in   1   system clock
//   rst_n       in   1   asynchronous active-low reset
//   key_valid   in   1   key event strobe
//   key_code    in   8   make code of the event
//   key_break   in   1   1 = release, 0 = press
//   key_ready   out  1   high while idle; events are dropped otherwise
//   half_period out  PW  tone divider compare value
//   tone_en     out  1   tone divider enable
//   period_load out  1   pulse when half_period or tone_en changes
//   held_count  out  4   occupied stack slots
module note_voice_arbiter
    import piano_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int PW          = 26,
    parameter int RELEASE_CYC = 2500000
) (
    input  logic          clkB,
    input  logic          rst_n,
    input  logic          key_valid,
    input  logic [7:0]    key_code,
    input  logic          key_break,
    output logic          key_ready,
    output logic [PW-1:0] half_period,
    output logic          tone_en,
    output logic          period_load,
    output logic [3:0]    held_count
);

    localparam int IW = $clog2(DEPTH);
    localparam int RW = $clog2(RELEASE_CYC + 1);

    arb_state_e       state_q, state_d;
    logic [7:0]       evCode_q;
    logic             evBreak_q;
    logic             matchHit_q, matchHit_d;
    logic [IW-1:0]    matchIdx_q, matchIdx_d;
    logic [7:0]       slotCode_q [DEPTH];
    logic [7:0]       slotCode_d [DEPTH];
    logic [PW-1:0]    slotPer_q [DEPTH];
    logic [PW-1:0]    slotPer_d [DEPTH];
    logic [DEPTH-1:0] slotVld_q, slotVld_d;
    logic [PW-1:0]    halfPeriod_q, halfPeriod_d;
    logic             toneEn_q, toneEn_d;
    logic             periodLoad_q, periodLoad_d;
    logic [RW-1:0]    relCnt_q, relCnt_d;
    logic [PW-1:0]    romPeriod;
    logic             accept;
    int               removeIdx;

    note_period_rom #(.PW(PW)) uRom (
        .clk      (clkB),
        .rst_n    (rst_n),
        .code_i   (evCode_q),
        .period_o (romPeriod)
    );

    assign key_ready = (state_q == ST_IDLE);
    assign accept    = key_valid && key_ready;

    always_ff @(posedge clkB or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // One event walks IDLE -> LOOKUP -> EDIT -> PUBLISH; no queueing of strobes.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (key_valid) state_d = ST_LOOKUP;
            ST_LOOKUP:  state_d = ST_EDIT;
            ST_EDIT:    state_d = ST_PUBLISH;
            ST_PUBLISH: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Codes in the stack are unique, so at most one slot can match.
    always_comb begin
        matchHit_d = 1'b0;
        matchIdx_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (slotVld_q[i] && (slotCode_q[i] == evCode_q)) begin
                matchHit_d = 1'b1;
                matchIdx_d = IW'(i);
            end
        end
    end

    // A press vacates the matching slot (or the bottom one when the code is new),
    // slides everything above it down and writes the new entry on top. A release
    // of a held code slides everything below the match up to close the gap.
    always_comb begin
        slotCode_d = slotCode_q;
        slotPer_d  = slotPer_q;
        slotVld_d  = slotVld_q;
        removeIdx  = matchHit_q ? int'(matchIdx_q) : DEPTH - 1;
        if ((state_q == ST_EDIT) && (romPeriod != '0)) begin
            if (!evBreak_q) begin
                for (int i = 1; i < DEPTH; i++) begin
                    if (i <= removeIdx) begin
                        slotCode_d[i] = slotCode_q[i-1];
                        slotPer_d[i]  = slotPer_q[i-1];
                        slotVld_d[i]  = slotVld_q[i-1];
                    end
                end
                slotCode_d[0] = evCode_q;
                slotPer_d[0]  = romPeriod;
                slotVld_d[0]  = 1'b1;
            end else if (matchHit_q) begin
                for (int i = 0; i < DEPTH - 1; i++) begin
                    if (i >= removeIdx) begin
                        slotCode_d[i] = slotCode_q[i+1];
                        slotPer_d[i]  = slotPer_q[i+1];
                        slotVld_d[i]  = slotVld_q[i+1];
                    end
                end
                slotCode_d[DEPTH-1] = '0;
                slotPer_d[DEPTH-1]  = '0;
                slotVld_d[DEPTH-1]  = 1'b0;
            end
        end
    end

    // Outputs are computed from the edited stack so they appear together with the
    // new held_count. The EDIT branches win over the countdown, which is what lets
    // a press arriving late in the release window keep the tone running.
    always_comb begin
        halfPeriod_d = halfPeriod_q;
        toneEn_d     = toneEn_q;
        periodLoad_d = 1'b0;
        relCnt_d     = relCnt_q;
        if ((state_q == ST_EDIT) && slotVld_d[0]) begin
            halfPeriod_d = slotPer_d[0];
            toneEn_d     = 1'b1;
            relCnt_d     = '0;
            periodLoad_d = (slotPer_d[0] != halfPeriod_q) || !toneEn_q;
        end else if ((state_q == ST_EDIT) && slotVld_q[0]) begin
            relCnt_d = RW'(RELEASE_CYC);
        end else if ((relCnt_q != '0) && !slotVld_q[0]) begin
            relCnt_d = relCnt_q - RW'(1);
            if (relCnt_q == RW'(1)) begin
                toneEn_d     = 1'b0;
                periodLoad_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clkB or negedge rst_n) begin
        if (!rst_n) begin
            evCode_q     <= '0;
            evBreak_q    <= 1'b0;
            matchHit_q   <= 1'b0;
            matchIdx_q   <= '0;
            slotVld_q    <= '0;
            halfPeriod_q <= '0;
            toneEn_q     <= 1'b0;
            periodLoad_q <= 1'b0;
            relCnt_q     <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                slotCode_q[i] <= '0;
                slotPer_q[i]  <= '0;
            end
        end else begin
            if (accept) begin
                evCode_q  <= key_code;
                evBreak_q <= key_break;
            end
            if (state_q == ST_LOOKUP) begin
                matchHit_q <= matchHit_d;
                matchIdx_q <= matchIdx_d;
            end
            slotCode_q   <= slotCode_d;
            slotPer_q    <= slotPer_d;
            slotVld_q    <= slotVld_d;
            halfPeriod_q <= halfPeriod_d;
            toneEn_q     <= toneEn_d;
            periodLoad_q <= periodLoad_d;
            relCnt_q     <= relCnt_d;
        end
    end

    always_comb begin
        held_count = '0;
        for (int i = 0; i < DEPTH; i++) begin
            held_count = held_count + 4'(slotVld_q[i]);
        end
    end

    assign half_period = halfPeriod_q;
    assign tone_en     = toneEn_q;
    assign period_load = periodLoad_q;

endmodule

// File: tb/tb_note_voice_arbiter.sv
// Bench for note_voice_arbiter: directed event table, hand-written corner sequences
// and random key traffic, all compared every cycle against an event-level model
// (held keys kept as a newest-first queue, release timeout kept as a deadline cycle).
module tb_note_voice_arbiter;

    localparam int DEPTH  = 4;
    localparam int PW     = 26;
    localparam int RELCYC = 8;

    logic          clkB;
    logic          rst_n;
    logic          key_valid;
    logic [7:0]    key_code;
    logic          key_break;
    logic          key_ready;
    logic [PW-1:0] half_period;
    logic          tone_en;
    logic          period_load;
    logic [3:0]    held_count;

    note_voice_arbiter #(.DEPTH(DEPTH), .PW(PW), .RELEASE_CYC(RELCYC)) dut (
        .clkB        (clkB),
        .rst_n       (rst_n),
        .key_valid   (key_valid),
        .key_code    (key_code),
        .key_break   (key_break),
        .key_ready   (key_ready),
        .half_period (half_period),
        .tone_en     (tone_en),
        .period_load (period_load),
        .held_count  (held_count)
    );

    initial clkB = 1'b0;
    always #5 clkB = ~clkB;

    typedef struct {
        logic [7:0] code;
        logic       brk;
        int         hp;
        logic       ten;
        int         cnt;
        logic       pl;
    } vec_t;

    vec_t       tbl [13];
    logic [7:0] pool [7];

    int total;
    int bad;
    int cyc;

    // reference model state
    logic [7:0] heldQ[$];
    int         expHp;
    logic       expTen;
    logic       expPl;
    logic       expRdy;
    int         offAt;
    int         pendAt;
    int         busyUntil;
    logic [7:0] pendCode;
    logic       pendBrk;

    // last sampled outputs, and the ones sampled at an event's publish cycle
    logic sRdy, sTen, sPl, sawToneLow;
    int   sHp, sCnt, sCyc;
    int   pHp, pCnt, lastPub;
    logic pTen, pPl;

    int   fallCyc;
    logic fallPl;
    logic rv, rb;
    logic [7:0] rc;

    function automatic int notePeriod(input logic [7:0] c);
        case (c)
            8'h1C:   return 95556;
            8'h1B:   return 85131;
            8'h23:   return 75843;
            8'h2B:   return 71586;
            8'h34:   return 63776;
            default: return 0;
        endcase
    endfunction

    task automatic checkVal(input string name, input int act, input int want);
        total++;
        if (act != want) begin
            bad++;
            $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, want);
        end
    endtask

    task automatic modelReset();
        heldQ.delete();
        expHp     = 0;
        expTen    = 1'b0;
        expPl     = 1'b0;
        expRdy    = 1'b1;
        offAt     = -1;
        pendAt    = -1;
        busyUntil = 0;
    endtask

    task automatic modelApplyEvent();
        int p;
        int idx;
        int was;
        int np;
        p   = notePeriod(pendCode);
        was = heldQ.size();
        if (p != 0) begin
            idx = -1;
            foreach (heldQ[i]) if (heldQ[i] == pendCode) idx = i;
            if (!pendBrk) begin
                if (idx >= 0) heldQ.delete(idx);
                else if (heldQ.size() == DEPTH) void'(heldQ.pop_back());
                heldQ.push_front(pendCode);
            end else if (idx >= 0) begin
                heldQ.delete(idx);
            end
        end
        if (heldQ.size() > 0) begin
            np     = notePeriod(heldQ[0]);
            expPl  = (np != expHp) || !expTen;
            expHp  = np;
            expTen = 1'b1;
            offAt  = -1;
        end else if (was > 0) begin
            offAt = cyc + RELCYC;
        end
    endtask

    task automatic modelCycle(input logic v, input logic [7:0] c, input logic b);
        expPl = 1'b0;
        if (cyc == pendAt) begin
            modelApplyEvent();
            pendAt = -1;
        end
        if (cyc == offAt) begin
            expTen = 1'b0;
            expPl  = 1'b1;
            offAt  = -1;
        end
        expRdy = (cyc >= busyUntil);
        if (v && expRdy) begin
            pendCode  = c;
            pendBrk   = b;
            pendAt    = cyc + 3;
            busyUntil = cyc + 4;
        end
    endtask

    task automatic checkOutput();
        checkVal("key_ready",   int'(key_ready),   int'(expRdy));
        checkVal("half_period", int'(half_period), expHp);
        checkVal("tone_en",     int'(tone_en),     int'(expTen));
        checkVal("period_load", int'(period_load), int'(expPl));
        checkVal("held_count",  int'(held_count),  heldQ.size());
    endtask

    // Called #1 after a rising edge; drives one cycle, checks it at the falling edge.
    task automatic applyStimulus(input logic v, input logic [7:0] c, input logic b);
        key_valid = v;
        key_code  = c;
        key_break = b;
        modelCycle(v, c, b);
        @(negedge clkB);
        checkOutput();
        sRdy = key_ready;
        sHp  = int'(half_period);
        sTen = tone_en;
        sPl  = period_load;
        sCnt = int'(held_count);
        sCyc = cyc;
        if (!tone_en) sawToneLow = 1'b1;
        @(posedge clkB);
        #1;
        cyc++;
    endtask

    task automatic runEvent(input logic [7:0] c, input logic b);
        applyStimulus(1'b1, c, b);
        applyStimulus(1'b0, 8'h00, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0);
        pHp     = sHp;
        pTen    = sTen;
        pCnt    = sCnt;
        pPl     = sPl;
        lastPub = sCyc;
        applyStimulus(1'b0, 8'h00, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        total      = 0;
        bad        = 0;
        cyc        = 0;
        sawToneLow = 1'b0;
        rst_n      = 1'b0;
        key_valid  = 1'b0;
        key_code   = 8'h00;
        key_break  = 1'b0;

        tbl[0]  = '{8'h1C, 1'b0, 95556, 1'b1, 1, 1'b1};
        tbl[1]  = '{8'h1B, 1'b0, 85131, 1'b1, 2, 1'b1};
        tbl[2]  = '{8'h1B, 1'b1, 95556, 1'b1, 1, 1'b1};
        tbl[3]  = '{8'h1C, 1'b0, 95556, 1'b1, 1, 1'b0};
        tbl[4]  = '{8'h1B, 1'b0, 85131, 1'b1, 2, 1'b1};
        tbl[5]  = '{8'h23, 1'b0, 75843, 1'b1, 3, 1'b1};
        tbl[6]  = '{8'h2B, 1'b0, 71586, 1'b1, 4, 1'b1};
        tbl[7]  = '{8'h34, 1'b0, 63776, 1'b1, 4, 1'b1};
        tbl[8]  = '{8'h1C, 1'b1, 63776, 1'b1, 4, 1'b0};
        tbl[9]  = '{8'h34, 1'b1, 71586, 1'b1, 3, 1'b1};
        tbl[10] = '{8'h2B, 1'b1, 75843, 1'b1, 2, 1'b1};
        tbl[11] = '{8'h23, 1'b1, 85131, 1'b1, 1, 1'b1};
        tbl[12] = '{8'h1B, 1'b1, 85131, 1'b1, 0, 1'b0};

        pool[0] = 8'h1C; pool[1] = 8'h1B; pool[2] = 8'h23; pool[3] = 8'h2B;
        pool[4] = 8'h34; pool[5] = 8'h00; pool[6] = 8'h15;

        modelReset();
        @(posedge clkB);
        #1;
        checkVal("reset_key_ready",   int'(key_ready),   1);
        checkVal("reset_half_period", int'(half_period), 0);
        checkVal("reset_tone_en",     int'(tone_en),     0);
        checkVal("reset_period_load", int'(period_load), 0);
        checkVal("reset_held_count",  int'(held_count),  0);
        @(posedge clkB);
        #1;
        rst_n = 1'b1;

        $display("[TB] directed event table");
        for (int k = 0; k < 13; k++) begin
            runEvent(tbl[k].code, tbl[k].brk);
            checkVal($sformatf("tbl%0d_half_period", k), pHp, tbl[k].hp);
            checkVal($sformatf("tbl%0d_tone_en", k), int'(pTen), int'(tbl[k].ten));
            checkVal($sformatf("tbl%0d_held_count", k), pCnt, tbl[k].cnt);
            checkVal($sformatf("tbl%0d_period_load", k), int'(pPl), int'(tbl[k].pl));
        end

        $display("[TB] release timeout");
        fallCyc = -1;
        fallPl  = 1'b0;
        for (int j = 0; j < 20 && fallCyc < 0; j++) begin
            applyStimulus(1'b0, 8'h00, 1'b0);
            if (!sTen) begin
                fallCyc = sCyc;
                fallPl  = sPl;
            end
        end
        checkVal("tone_fall_seen", int'(fallCyc >= 0), 1);
        checkVal("tone_fall_delay", fallCyc - lastPub, RELCYC);
        checkVal("tone_fall_load", int'(fallPl), 1);

        $display("[TB] press late in the release window");
        runEvent(8'h1C, 1'b0);
        runEvent(8'h1C, 1'b1);
        sawToneLow = 1'b0;
        applyStimulus(1'b0, 8'h00, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0);
        runEvent(8'h23, 1'b0);
        checkVal("late_press_no_gap", int'(sawToneLow), 0);
        checkVal("late_press_half_period", pHp, 75843);
        checkVal("late_press_held_count", pCnt, 1);

        $display("[TB] unmapped code");
        runEvent(8'h00, 1'b0);
        checkVal("unmapped_half_period", pHp, 75843);
        checkVal("unmapped_held_count", pCnt, 1);
        checkVal("unmapped_period_load", int'(pPl), 0);

        $display("[TB] strobe while busy");
        applyStimulus(1'b1, 8'h1C, 1'b0);
        applyStimulus(1'b1, 8'h1B, 1'b0);
        checkVal("busy_key_ready", int'(sRdy), 0);
        applyStimulus(1'b0, 8'h00, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkVal("busy_half_period", sHp, 95556);
        applyStimulus(1'b0, 8'h00, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkVal("busy_held_count", sCnt, 2);

        $display("[TB] reset during EDIT");
        runEvent(8'h1B, 1'b0);
        checkVal("pre_reset_held_count", pCnt, 3);
        applyStimulus(1'b1, 8'h2B, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        checkVal("midreset_key_ready",   int'(key_ready),   1);
        checkVal("midreset_half_period", int'(half_period), 0);
        checkVal("midreset_tone_en",     int'(tone_en),     0);
        checkVal("midreset_period_load", int'(period_load), 0);
        checkVal("midreset_held_count",  int'(held_count),  0);
        modelReset();
        @(posedge clkB);
        #1;
        rst_n = 1'b1;
        cyc   = cyc + 2;
        runEvent(8'h23, 1'b0);
        checkVal("post_reset_held_count", pCnt, 1);
        checkVal("post_reset_half_period", pHp, 75843);
        checkVal("post_reset_period_load", int'(pPl), 1);

        $display("[TB] random key traffic");
        for (int r = 0; r < 800; r++) begin
            rv = ($urandom_range(0, 3) == 0);
            rc = pool[$urandom_range(0, 6)];
            rb = ($urandom_range(0, 4) < 2);
            applyStimulus(rv, rc, rb);
        end
        for (int r = 0; r < 16; r++) begin
            applyStimulus(1'b0, 8'h00, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
